membus_arb: RTL and testbench
=============================

MEMBUS_ARB -- requirements
Module: membus_arb

Interface
REQ-001 SHALL have parameter WFIFO_DEPTH, default 2, the posted-write FIFO depth (power of two, 2..8).
REQ-002 SHALL have parameter TIMEOUT, default 255, the bus-wait limit in cycles (used only with REQ-030).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports i_iaddr input 32 and i_iread_en input 1, the core's instruction fetch request.
REQ-006 SHALL have ports o_inst output 32 and o_iread_vd output 1, the fetched word and its one-cycle valid strobe.
REQ-007 SHALL have ports i_memaddr input 32, i_read_en input 1, i_write_en input 1 and i_write_data input 32, the core data request.
REQ-008 SHALL have port i_hold  input  1, high when the core pipeline is stalled; it qualifies write pushes.
REQ-009 SHALL have ports o_read_data output 32 and o_read_vd output 1, the load data and its one-cycle valid strobe.
REQ-010 SHALL have port o_wstall  output  1, a combinational request for the core to stall because the write FIFO is full.
REQ-011 SHALL have ports o_maddr output 32, o_mwdata output 32, o_mwe output 1 and o_mreq output 1, the single memory-bus request.
REQ-012 SHALL have ports i_mack input 1 and i_mrdata input 32, the memory acknowledge and the read data valid with it.
REQ-013 SHALL have port o_bus_err  output  1, a sticky bus-timeout flag.

Function
REQ-014 SHALL use FSM states IDLE, DREAD, WDRAIN, IFETCH and RESP, and shall be in IDLE after reset.
REQ-015 SHALL push {i_memaddr, i_write_data} into the FIFO when i_write_en && !i_hold && FIFO not full; exactly one push per core write.
REQ-016 SHALL drive o_wstall = i_write_en && FIFO full; the write is not lost and is pushed on the first cycle with space.
REQ-017 SHALL select the next state from IDLE with this priority: FIFO non-empty -> WDRAIN; else i_read_en -> DREAD; else i_iread_en -> IFETCH.
REQ-018 SHALL issue no data read while the FIFO is non-empty, giving read-after-write ordering.
REQ-019 SHALL hold o_mreq=1 and hold o_maddr, o_mwe and o_mwdata stable in DREAD, WDRAIN and IFETCH until the cycle i_mack=1.
REQ-020 SHALL drive o_mwe=1 only in WDRAIN and pop the FIFO head on i_mack, then return to IDLE.
REQ-021 SHALL, on i_mack in DREAD or IFETCH, register i_mrdata and go to RESP.
REQ-022 SHALL, in RESP, pulse the matching o_read_vd or o_iread_vd for exactly one cycle with data valid, then return to IDLE.
REQ-023 SHALL give a minimum read latency of 3 cycles from request to valid strobe, with zero-wait memory (mack in the first request cycle).
REQ-024 SHALL allow a push and a pop in the same cycle; occupancy is then unchanged and pointers wrap modulo WFIFO_DEPTH.
REQ-025 SHALL register o_inst and o_read_data, holding the last value between strobes.
REQ-026 SHALL deliver no strobe when a requester drops its request before RESP; the completed transaction is discarded silently.

Reset
REQ-027 SHALL, when rst=0, asynchronously force the FSM to IDLE, empty the FIFO and zero both pointers and the timeout counter.
REQ-028 SHALL, in reset, drive o_mreq, o_mwe, o_iread_vd, o_read_vd and o_bus_err to 0, and o_inst, o_read_data, o_maddr and o_mwdata to 0.
REQ-029 SHALL abandon any in-flight transaction on reset mid-operation, discarding posted writes.

Configuration
REQ-030 SHALL, with MEMBUS_ARB_TIMEOUT_EN defined, count cycles spent waiting in DREAD, WDRAIN or IFETCH.
- On reaching TIMEOUT: set o_bus_err (sticky until reset), abort the transaction and go to RESP.
- Read returns 32'h0000_0013 for IFETCH, 32'h0 for DREAD.
- WDRAIN pops the entry without a strobe.
REQ-031 SHALL, without MEMBUS_ARB_TIMEOUT_EN, wait indefinitely for i_mack and tie o_bus_err to 0; no counter logic is present.

Verification
REQ-032 SHALL cover: ifetch 0x100, mem acks after 2 wait cycles with 0x00500093 -> o_iread_vd one cycle, o_inst=0x00500093, mreq high 3 cycles.
REQ-033 SHALL cover: simultaneous i_read_en addr 0x2000 and i_iread_en -> DREAD is served first, ifetch follows.
REQ-034 SHALL cover: three back-to-back writes with i_hold=0, mem stalled, depth 2 -> third write asserts o_wstall until first drain ack; all three reach memory in order.
REQ-035 SHALL cover: write 0xAA to 0x40, then read 0x40 the next cycle -> the write reaches memory before the read request; read returns the memory value.
REQ-036 SHALL cover: rst=0 asserted during WDRAIN with 2 entries -> next cycle o_mreq=0, FIFO empty, IDLE.
REQ-037 SHALL cover, with MEMBUS_ARB_TIMEOUT_EN and TIMEOUT=4: ifetch never acked -> o_iread_vd with o_inst=0x00000013 and o_bus_err=1 until reset.

Source files
------------

// File: rtl/membus_arb.sv
// membus_arb: one memory bus shared by instruction fetch, data loads and posted writes.
// Define MEMBUS_ARB_TIMEOUT_EN to add a bus-wait timeout with a sticky o_bus_err flag.
module membus_arb #(
    parameter int WFIFO_DEPTH = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_iaddr,
    input  logic        i_iread_en,
    output logic [31:0] o_inst,
    output logic        o_iread_vd,
    input  logic [31:0] i_memaddr,
    input  logic        i_read_en,
    input  logic        i_write_en,
    input  logic [31:0] i_write_data,
    input  logic        i_hold,
    output logic [31:0] o_read_data,
    output logic        o_read_vd,
    output logic        o_wstall,
    output logic [31:0] o_maddr,
    output logic [31:0] o_mwdata,
    output logic        o_mwe,
    output logic        o_mreq,
    input  logic        i_mack,
    input  logic [31:0] i_mrdata,
    output logic        o_bus_err
);
    localparam int PW = $clog2(WFIFO_DEPTH);
    localparam int CW = PW + 1;

    if (WFIFO_DEPTH < 2 || WFIFO_DEPTH > 8 || (WFIFO_DEPTH & (WFIFO_DEPTH - 1)) != 0 || TIMEOUT < 1)
    begin : g_bad_param
        $error("membus_arb: WFIFO_DEPTH must be a power of two in 2..8 and TIMEOUT >= 1");
    end

    typedef enum logic [2:0] {IDLE, DREAD, WDRAIN, IFETCH, RESP} state_t;
    state_t state, state_nxt;

    logic [31:0]   fifo_addr [WFIFO_DEPTH];
    logic [31:0]   fifo_data [WFIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          full, empty, push, pop;
    logic [31:0]   req_addr;
    logic [31:0]   rsp_data;
    logic          waiting, done, tmo;

    assign full     = (count == CW'(WFIFO_DEPTH));
    assign empty    = (count == '0);
    assign push     = i_write_en && !i_hold && !full;
    assign o_wstall = i_write_en && full;
    assign waiting  = (state == DREAD) || (state == WDRAIN) || (state == IFETCH);
    // A bus transaction ends either on acknowledge or on an expired wait.
    assign done     = waiting && (i_mack || tmo);
    assign pop      = (state == WDRAIN) && done;
    assign rsp_data = !tmo ? i_mrdata : ((state == IFETCH) ? 32'h0000_0013 : 32'h0);

`ifdef MEMBUS_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt;
    logic          bus_err;

    assign tmo       = waiting && !i_mack && (tmo_cnt == TW'(TIMEOUT - 1));
    assign o_bus_err = bus_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt <= '0;
            bus_err <= 1'b0;
        end else begin
            if (waiting && !done) tmo_cnt <= tmo_cnt + 1'b1;
            else                  tmo_cnt <= '0;
            if (tmo) bus_err <= 1'b1;
        end
    end
`else
    assign tmo       = 1'b0;
    assign o_bus_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Pending posted writes always win so a later load sees them in memory.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (!empty)          state_nxt = WDRAIN;
                else if (i_read_en)  state_nxt = DREAD;
                else if (i_iread_en) state_nxt = IFETCH;
            end
            DREAD, IFETCH: if (done) state_nxt = RESP;
            WDRAIN:        if (done) state_nxt = tmo ? RESP : IDLE;
            RESP:          state_nxt = IDLE;
            default:       state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_mreq   = 1'b0;
        o_mwe    = 1'b0;
        o_maddr  = '0;
        o_mwdata = '0;
        case (state)
            DREAD, IFETCH: begin
                o_mreq  = 1'b1;
                o_maddr = req_addr;
            end
            WDRAIN: begin
                o_mreq   = 1'b1;
                o_mwe    = 1'b1;
                o_maddr  = fifo_addr[rd_ptr];
                o_mwdata = fifo_data[rd_ptr];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= i_memaddr;
            fifo_data[wr_ptr] <= i_write_data;
        end
        if (state == IDLE) req_addr <= i_read_en ? i_memaddr : i_iaddr;
    end

    // Strobe shows during RESP; a requester that has gone away gets nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            o_inst      <= '0;
            o_read_data <= '0;
            o_iread_vd  <= 1'b0;
            o_read_vd   <= 1'b0;
        end else begin
            o_iread_vd <= 1'b0;
            o_read_vd  <= 1'b0;
            if (done && state == IFETCH && i_iread_en) begin
                o_inst     <= rsp_data;
                o_iread_vd <= 1'b1;
            end
            if (done && state == DREAD && i_read_en) begin
                o_read_data <= rsp_data;
                o_read_vd   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_membus_arb.sv
// Bench for membus_arb: memory responder, program-order memory model and per-cycle bus checks.
module tb_membus_arb;
    localparam int DEPTH = 2;
    localparam int TMO   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_iaddr, i_memaddr, i_write_data, i_mrdata;
    logic        i_iread_en, i_read_en, i_write_en, i_hold, i_mack;
    logic [31:0] o_inst, o_read_data, o_maddr, o_mwdata;
    logic        o_iread_vd, o_read_vd, o_wstall, o_mwe, o_mreq, o_bus_err;

    always #5 clk = ~clk;

    membus_arb #(.WFIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .i_iaddr(i_iaddr), .i_iread_en(i_iread_en), .o_inst(o_inst), .o_iread_vd(o_iread_vd),
        .i_memaddr(i_memaddr), .i_read_en(i_read_en), .i_write_en(i_write_en),
        .i_write_data(i_write_data), .i_hold(i_hold),
        .o_read_data(o_read_data), .o_read_vd(o_read_vd), .o_wstall(o_wstall),
        .o_maddr(o_maddr), .o_mwdata(o_mwdata), .o_mwe(o_mwe), .o_mreq(o_mreq),
        .i_mack(i_mack), .i_mrdata(i_mrdata), .o_bus_err(o_bus_err)
    );

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory seen by the bus, and memory as the program expects it (updated at each accepted write).
    logic [31:0] bus_mem  [logic [31:0]];
    logic [31:0] prog_mem [logic [31:0]];
    logic [32:0] bus_log  [$];
    logic [63:0] exp_wq   [$];

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction
    function automatic logic [31:0] bus_rd(input logic [31:0] a);
        return bus_mem.exists(a) ? bus_mem[a] : dflt(a);
    endfunction
    function automatic logic [31:0] prog_rd(input logic [31:0] a);
        return prog_mem.exists(a) ? prog_mem[a] : dflt(a);
    endfunction

    int          wait_cfg = 0;
    int          waitcnt = 0;
    int          occ = 0;
    int          prev_occ = 0;
    int          mreq_cycles = 0;
    int          stall_cycles = 0;
    int          rd_cyc = 0;
    int          if_cyc = 0;
    bit          rd_pend = 0;
    bit          if_pend = 0;
    logic [31:0] rd_exp = '0;
    logic [31:0] if_exp = '0;
    logic        mreq_q = 0, mack_q = 0, mwe_q = 0;
    logic [31:0] maddr_q = '0, mwdata_q = '0;

    always @(negedge clk) begin
        bit push, pop;
        cyc++;
        if (!rst) begin
            occ = 0; prev_occ = 0; waitcnt = 0; mreq_q = 0;
            exp_wq.delete();
            i_mack = 0;
            i_mrdata = '0;
        end else begin
            i_mack = 0;
            i_mrdata = '0;
            if (o_mreq) begin
                if (wait_cfg >= 0 && waitcnt >= wait_cfg) begin
                    i_mack = 1;
                    waitcnt = 0;
                    bus_log.push_back({o_mwe, o_maddr});
                    if (o_mwe) begin
                        bus_mem[o_maddr] = o_mwdata;
                        check("drain_expected", exp_wq.size() != 0, 1);
                        if (exp_wq.size() != 0) check("drain_order", {o_maddr, o_mwdata}, exp_wq.pop_front());
                    end else begin
                        i_mrdata = bus_rd(o_maddr);
                    end
                end else begin
                    waitcnt++;
                end
            end else begin
                waitcnt = 0;
            end

            check("wstall", o_wstall, i_write_en && (occ == DEPTH));
            if (o_mreq) mreq_cycles++;
            if (o_wstall) stall_cycles++;
            if (o_mwe) check("mwe_without_mreq", o_mreq, 1);
            if (o_mreq && mreq_q && !mack_q) begin
                check("bus_hold_addr", {o_mwe, o_maddr}, {mwe_q, maddr_q});
                check("bus_hold_wdata", o_mwdata, mwdata_q);
            end
            if (o_mreq && !o_mwe && !mreq_q) check("read_after_write", prev_occ, 0);
            if (o_read_vd) begin
                check("rd_vd_expected", rd_pend, 1);
                check("read_data", o_read_data, rd_exp);
                rd_pend = 0;
                rd_cyc = cyc;
            end
            if (o_iread_vd) begin
                check("if_vd_expected", if_pend, 1);
                check("inst_data", o_inst, if_exp);
                if_pend = 0;
                if_cyc = cyc;
            end
`ifndef MEMBUS_ARB_TIMEOUT_EN
            check("bus_err_tied", o_bus_err, 0);
`endif
            push = i_write_en && !i_hold && (occ < DEPTH);
            pop  = o_mreq && o_mwe && i_mack;
            if (push) begin
                exp_wq.push_back({i_memaddr, i_write_data});
                prog_mem[i_memaddr] = i_write_data;
            end
            prev_occ = occ;
            occ = occ + int'(push) - int'(pop);
            mreq_q = o_mreq; mack_q = i_mack; mwe_q = o_mwe;
            maddr_q = o_maddr; mwdata_q = o_mwdata;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rd(input string name);
        int k = 0;
        while (rd_pend && k < 60) begin @(posedge clk); #1; k++; end
        check({name, "_rd_done"}, rd_pend, 0);
    endtask

    task automatic wait_if(input string name);
        int k = 0;
        while (if_pend && k < 60) begin @(posedge clk); #1; k++; end
        check({name, "_if_done"}, if_pend, 0);
    endtask

    task automatic core_write(input logic [31:0] a, input logic [31:0] d);
        int k = 0;
        i_write_en = 1; i_memaddr = a; i_write_data = d;
        @(negedge clk);
        while (o_wstall && k < 60) begin @(negedge clk); k++; end
        check("write_accepted", o_wstall, 0);
        @(posedge clk); #1;
        i_write_en = 0;
    endtask

    task automatic wait_drained();
        int k = 0;
        @(negedge clk);
        while ((exp_wq.size() != 0 || o_mreq) && k < 100) begin @(negedge clk); k++; end
        check("drained", exp_wq.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int req_cyc;
        rst = 0;
        i_iaddr = '0; i_iread_en = 0; i_memaddr = '0; i_read_en = 0;
        i_write_en = 0; i_write_data = '0; i_hold = 0; i_mack = 0; i_mrdata = '0;
        bus_mem[32'h100]  = 32'h0050_0093;
        prog_mem[32'h100] = 32'h0050_0093;
        tick(3);
        check("rst_mreq", o_mreq, 0);
        check("rst_mwe", o_mwe, 0);
        check("rst_maddr", o_maddr, 0);
        check("rst_mwdata", o_mwdata, 0);
        check("rst_strobes", {o_iread_vd, o_read_vd, o_bus_err}, 0);
        check("rst_data", {o_inst, o_read_data}, 0);
        rst = 1;
        tick(2);

        // Fetch with two wait states.
        wait_cfg = 2; mreq_cycles = 0;
        if_exp = prog_rd(32'h100); if_pend = 1;
        i_iaddr = 32'h100; i_iread_en = 1;
        wait_if("ifetch");
        i_iread_en = 0;
        check("ifetch_inst_lit", o_inst, 32'h0050_0093);
        check("ifetch_mreq_cycles", mreq_cycles, 3);
        tick(2);

        // Zero-wait load latency.
        wait_cfg = 0;
        rd_exp = prog_rd(32'h80); rd_pend = 1;
        req_cyc = cyc + 1;
        i_memaddr = 32'h80; i_read_en = 1;
        wait_rd("zero_wait");
        i_read_en = 0;
        check("read_latency", rd_cyc - req_cyc, 2);
        check("zero_wait_data_lit", o_read_data, 32'h5A5A_0080);
        tick(2);

        // Simultaneous load and fetch: load first.
        wait_cfg = 1; bus_log.delete();
        rd_exp = prog_rd(32'h2000); rd_pend = 1;
        if_exp = prog_rd(32'h104);  if_pend = 1;
        i_memaddr = 32'h2000; i_read_en = 1;
        i_iaddr = 32'h104; i_iread_en = 1;
        wait_rd("prio");
        i_read_en = 0;
        wait_if("prio");
        i_iread_en = 0;
        check("dread_first", rd_cyc < if_cyc, 1);
        check("prio_bus0", bus_log.size() > 0 ? bus_log[0] : 33'h0, {1'b0, 32'h2000});
        check("prio_bus1", bus_log.size() > 1 ? bus_log[1] : 33'h0, {1'b0, 32'h104});
        tick(2);

        // Three back-to-back writes against a slow memory.
        wait_cfg = 2; bus_log.delete(); stall_cycles = 0;
        core_write(32'h10, 32'h111);
        core_write(32'h14, 32'h222);
        core_write(32'h18, 32'h333);
        wait_drained();
        check("wstall_cycles", stall_cycles, 3);
        check("wr_order", {bus_log.size() > 2 ? bus_log[2] : 33'h0, bus_log.size() > 0 ? bus_log[0][31:0] : 32'h0},
              {1'b1, 32'h18, 32'h10});
        check("wr_mem_18", bus_rd(32'h18), 32'h333);
        tick(2);

        // Write then read of the same word on the next cycle.
        wait_cfg = 1; bus_log.delete();
        core_write(32'h40, 32'hAA);
        rd_exp = prog_rd(32'h40); rd_pend = 1;
        i_memaddr = 32'h40; i_read_en = 1;
        wait_rd("raw");
        i_read_en = 0;
        check("raw_data_lit", o_read_data, 32'hAA);
        check("raw_bus0", bus_log.size() > 0 ? bus_log[0] : 33'h0, {1'b1, 32'h40});
        check("raw_bus1", bus_log.size() > 1 ? bus_log[1] : 33'h0, {1'b0, 32'h40});
        tick(2);

        // Held pipeline must not push; exactly one push once released.
        wait_cfg = 0; bus_log.delete();
        i_hold = 1; i_write_en = 1; i_memaddr = 32'h60; i_write_data = 32'h66;
        tick(3);
        check("hold_no_drain", bus_log.size(), 0);
        i_hold = 0;
        tick(1);
        i_write_en = 0;
        wait_drained();
        check("hold_one_write", bus_log.size(), 1);
        tick(2);

        // Reset in the middle of a drain with two entries posted.
        wait_cfg = -1;
        core_write(32'h500, 32'h1);
        core_write(32'h504, 32'h2);
        @(negedge clk);
        check("drain_active", {o_mreq, o_mwe}, 2'b11);
        check("occ_before_rst", occ, 2);
        rst = 0;
        #1;
        check("rst_async_mreq", {o_mreq, o_mwe, o_maddr}, 0);
        wait_cfg = 0;
        @(posedge clk); #1;
        rst = 1;
        mreq_cycles = 0;
        tick(4);
        check("rst_fifo_empty", mreq_cycles, 0);

`ifdef MEMBUS_ARB_TIMEOUT_EN
        // Fetch that is never acknowledged.
        wait_cfg = -1;
        check("bus_err_before", o_bus_err, 0);
        if_exp = 32'h0000_0013; if_pend = 1;
        i_iaddr = 32'h300; i_iread_en = 1;
        wait_if("timeout");
        i_iread_en = 0;
        check("timeout_inst_lit", o_inst, 32'h0000_0013);
        check("bus_err_set", o_bus_err, 1);
        tick(3);
        check("bus_err_sticky", o_bus_err, 1);
        wait_cfg = 0;
        rst = 0;
        tick(1);
        rst = 1;
        tick(1);
        check("bus_err_cleared", o_bus_err, 0);
`endif

        tick(2);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete, %0d/%0d checks passed", checks - fails, checks);
        $fatal(1);
    end
endmodule
